// File: rtl/cnn16_fpmul_pipe_pkg.sv
// Shared FP16 constants, operand/result classification types and a classifier helper
// used by the multi-lane FP16 multiply pipeline.
package cnn16_fpmul_pipe_pkg;

    localparam int unsigned LANE_W   = 16;
    localparam int unsigned BIAS     = 15;
    localparam logic [4:0]  EXP_ONES = 5'h1F;
    localparam logic [15:0] QNAN     = 16'h7E00;
    localparam logic [15:0] POS_INF  = 16'h7C00;

    typedef struct packed {
        logic is_nan;
        logic is_inf;
        logic is_zero;
    } fp_kind_t;

    typedef struct packed {
        logic nan;
        logic inf;
        logic zero;
    } res_cls_t;

    // Subnormals share exponent field 0 with zero and are flushed.
    function automatic fp_kind_t fp16_kind(input logic [14:0] mag);
        fp_kind_t k;
        k.is_zero = (mag[14:10] == 5'h00);
        k.is_inf  = (mag[14:10] == EXP_ONES) && (mag[9:0] == 10'h000);
        k.is_nan  = (mag[14:10] == EXP_ONES) && (mag[9:0] != 10'h000);
        return k;
    endfunction

endpackage

// File: rtl/cnn16_fp16_mul_lane.sv
// One FP16 multiply lane: S1 decode/multiply, S2 normalise/exponent, S3 specials/ReLU.
// Datapath registers only; the enclosing pipeline supplies the advance enable.
module cnn16_fp16_mul_lane
    import cnn16_fpmul_pipe_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              relu,
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    output logic [LANE_W-1:0] p
);

    localparam logic signed [6:0] EXP_MAX = 7'sd31;
    localparam logic signed [6:0] EXP_MIN = 7'sd0;

    fp_kind_t   ka, kb;
    res_cls_t   cls1_c;

    logic        s1_sign;
    logic [4:0]  s1_ea, s1_eb;
    logic [21:0] s1_prod;
    res_cls_t    s1_cls;

    logic              norm;
    logic signed [6:0] exp2_c;
    logic [9:0]        frac2_c;

    logic              s2_sign;
    logic signed [6:0] s2_exp;
    logic [9:0]        s2_frac;
    res_cls_t          s2_cls;

    logic [LANE_W-1:0] res3_c;

    // S1 operand classification
    always_comb begin
        ka          = fp16_kind(a[14:0]);
        kb          = fp16_kind(b[14:0]);
        cls1_c.nan  = ka.is_nan | kb.is_nan | (ka.is_inf & kb.is_zero) | (kb.is_inf & ka.is_zero);
        cls1_c.inf  = (ka.is_inf | kb.is_inf) & ~cls1_c.nan;
        cls1_c.zero = (ka.is_zero | kb.is_zero) & ~cls1_c.nan;
    end

    // S2 normalisation: a product >= 2.0 has its leading one at bit 21
    always_comb begin
        norm    = s1_prod[21];
        exp2_c  = 7'({2'b00, s1_ea}) + 7'({2'b00, s1_eb}) - 7'(BIAS) + 7'(norm);
        frac2_c = norm ? s1_prod[20:11] : s1_prod[19:10];
    end

    // S3 special-case resolution and ReLU
    always_comb begin
        res3_c = {s2_sign, s2_exp[4:0], s2_frac};
        if (s2_cls.nan)
            res3_c = QNAN;
        else if (s2_cls.inf || (s2_exp >= EXP_MAX))
            res3_c = POS_INF | {s2_sign, 15'h0000};
        else if (s2_cls.zero || (s2_exp <= EXP_MIN))
            res3_c = {s2_sign, 15'h0000};
        if (relu && res3_c[15] && !s2_cls.nan)
            res3_c = 16'h0000;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_sign <= 1'b0;
            s1_ea   <= 5'h00;
            s1_eb   <= 5'h00;
            s1_prod <= 22'h0;
            s1_cls  <= '0;
            s2_sign <= 1'b0;
            s2_exp  <= 7'sd0;
            s2_frac <= 10'h000;
            s2_cls  <= '0;
            p       <= '0;
        end else if (en) begin
            s1_sign <= a[15] ^ b[15];
            s1_ea   <= a[14:10];
            s1_eb   <= b[14:10];
            s1_prod <= 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
            s1_cls  <= cls1_c;
            s2_sign <= s1_sign;
            s2_exp  <= exp2_c;
            s2_frac <= frac2_c;
            s2_cls  <= s1_cls;
            p       <= res3_c;
        end
    end

endmodule

// File: rtl/cnn16_fpmul_pipe.sv
// LANES-wide FP16 multiply pipeline with valid/ready handshake, per-set ReLU
// and a delivered-result counter.
module cnn16_fpmul_pipe
    import cnn16_fpmul_pipe_pkg::*;
#(
    parameter int unsigned LANES = 4,
    parameter int unsigned CNT_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANE_W*LANES-1:0] in_a,
    input  logic [LANE_W*LANES-1:0] in_b,
    input  logic                    in_relu,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANE_W*LANES-1:0] out_p,
    input  logic                    cnt_clr,
    output logic [CNT_W-1:0]        res_cnt
);

    logic adv;
    logic v1, v2;
    logic r1, r2;

    // Whole pipeline moves together; a full output stage blocks everything behind it
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            r1        <= 1'b0;
            r2        <= 1'b0;
        end else if (adv) begin
            v1        <= in_valid;
            r1        <= in_relu;
            v2        <= v1;
            r2        <= r1;
            out_valid <= v2;
        end
    end

    // Clear takes priority over a coincident output transfer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            res_cnt <= '0;
        else if (cnt_clr)
            res_cnt <= '0;
        else if (out_valid && out_ready)
            res_cnt <= res_cnt + CNT_W'(1);
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        cnn16_fp16_mul_lane u_lane (
            .clk  (clk),
            .rst  (rst),
            .en   (adv),
            .relu (r2),
            .a    (in_a[LANE_W*g +: LANE_W]),
            .b    (in_b[LANE_W*g +: LANE_W]),
            .p    (out_p[LANE_W*g +: LANE_W])
        );
    end

endmodule

// File: tb/tb_cnn16_fpmul_pipe.sv
// Scoreboard bench for cnn16_fpmul_pipe: directed FP16 vectors, backpressure,
// mid-stream reset and counter clear/wrap.
module tb_cnn16_fpmul_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_a = '0;
    logic [63:0] in_b = '0;
    logic        in_relu = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_p;
    logic        cnt_clr = 1'b0;
    logic [31:0] res_cnt;

    logic        c_in_valid = 1'b0;
    logic        c_in_ready;
    logic        c_out_valid;
    logic [15:0] c_out_p;
    logic [3:0]  c_res_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [63:0] q_p[$];
    int          q_cyc[$];
    bit          q_lat[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cnn16_fpmul_pipe #(.LANES(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_relu(in_relu),
        .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p),
        .cnt_clr(cnt_clr), .res_cnt(res_cnt)
    );

    cnn16_fpmul_pipe #(.LANES(1), .CNT_W(4)) dut_c (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_a(16'h3C00), .in_b(16'h3C00), .in_relu(1'b0),
        .out_valid(c_out_valid), .out_ready(1'b1), .out_p(c_out_p),
        .cnt_clr(1'b0), .res_cnt(c_res_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present one set; record its expected result once it is accepted
    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic relu,
                        input logic [63:0] e, input bit push, input bit lat);
        int n = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_relu  = relu;
        #1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1 within 50 cycles");
            in_valid = 1'b0;
            return;
        end
        if (push) begin
            q_p.push_back(e);
            q_cyc.push_back(cyc + 3);
            q_lat.push_back(lat);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (q_p.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q_p.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q_p.size());
        end
        repeat (2) @(negedge clk);
        #1;
    endtask

    // Monitor: pops expected results on each output transfer and watches stalls
    bit          prev_stall = 1'b0;
    logic [63:0] prev_p = '0;
    initial begin
        logic [63:0] ep;
        int          ec;
        bit          el;
        forever begin
            @(negedge clk);
            #4;
            if (!rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_hold_valid", 64'(out_valid), 64'd1);
                    chk("stall_hold_p", out_p, prev_p);
                end
                if (out_valid && !out_ready)
                    chk("stall_in_ready", 64'(in_ready), 64'd0);
                if (out_valid && out_ready) begin
                    if (q_p.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out: got %h expected no output", out_p);
                    end else begin
                        ep = q_p.pop_front();
                        ec = q_cyc.pop_front();
                        el = q_lat.pop_front();
                        chk("out_p", out_p, ep);
                        if (el) chk("latency_cycle", 64'(cyc), 64'(ec));
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_p     = out_p;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected finish before 300us");
        $fatal(1, "watchdog");
    end

    logic [63:0] ta[6], tbv[6], te[6];
    bit          tr[6];
    logic [15:0] bv[8];

    initial begin
        logic [63:0] bb;
        int n;

        // lane 0 is the rightmost 16 bits
        ta[0] = 64'hC000_0000_3E00_3C00; tbv[0] = 64'h3C00_5000_3E00_4000; te[0] = 64'hC000_0000_4080_4000; tr[0] = 1'b0;
        ta[1] = 64'h7E00_7C00_0400_7BFF; tbv[1] = 64'h3C00_0000_0400_7BFF; te[1] = 64'h7E00_7E00_0000_7C00; tr[1] = 1'b0;
        ta[2] = 64'h4000_3C00_8000_FC00; tbv[2] = 64'h0001_7C00_3C00_3C00; te[2] = 64'h0000_7C00_8000_FC00; tr[2] = 1'b0;
        ta[3] = 64'h4000_0400_0400_7800; tbv[3] = 64'h7E01_3C00_3800_4000; te[3] = 64'h7E00_0400_0000_7C00; tr[3] = 1'b0;
        ta[4] = 64'h4000_8000_7E00_BC00; tbv[4] = 64'h4000_3C00_3C00_3C00; te[4] = 64'h4400_0000_7E00_0000; tr[4] = 1'b1;
        ta[5] = 64'h4000_8000_7E00_BC00; tbv[5] = 64'h4000_3C00_3C00_3C00; te[5] = 64'h4400_8000_7E00_BC00; tr[5] = 1'b0;
        bv = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500, 16'h4600, 16'h4700, 16'h4800};

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_res_cnt", 64'(res_cnt), 64'd0);
        chk("rst_out_p", out_p, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Directed vectors back to back, no stall
        for (int k = 0; k < 6; k++) send(ta[k], tbv[k], tr[k], te[k], 1'b1, 1'b1);
        wait_drain();
        chk("cnt_after_directed", 64'(res_cnt), 64'd6);

        // Clear coincident with an output transfer
        send(ta[0], tbv[0], 1'b0, te[0], 1'b1, 1'b1);
        n = 0;
        while (!out_valid && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("clr_wait_valid", 64'(out_valid), 64'd1);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        #1;
        chk("clr_wins", 64'(res_cnt), 64'd0);
        wait_drain();

        // Eight back-to-back sets with a stall in the middle
        fork
            begin
                for (int k = 0; k < 8; k++) begin
                    for (int i = 0; i < 4; i++) bb[16*i +: 16] = bv[(k + i) % 8];
                    send({4{16'h3C00}}, bb, 1'b0, bb, 1'b1, 1'b0);
                end
            end
            begin
                repeat (3) @(negedge clk);
                out_ready = 1'b0;
                repeat (5) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        wait_drain();
        chk("cnt_after_backpressure", 64'(res_cnt), 64'd8);

        // Reset with three sets in flight; none may ever appear
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) send(ta[k], tbv[k], 1'b0, 64'd0, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_res_cnt", 64'(res_cnt), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        chk("midrst_no_emit_cnt", 64'(res_cnt), 64'd0);
        chk("midrst_out_valid_after", 64'(out_valid), 64'd0);

        // Narrow counter wraps: 17 transfers on a 4-bit counter
        c_in_valid = 1'b1;
        repeat (17) @(negedge clk);
        c_in_valid = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        chk("wrap_res_cnt", 64'(c_res_cnt), 64'd1);
        chk("wrap_out_valid", 64'(c_out_valid), 64'd0);
        chk("wrap_last_p", 64'(c_out_p), 64'h3C00);
        chk("wrap_in_ready", 64'(c_in_ready), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
